// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart transmit arbiter and its picker.
package uart_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned HOLD_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_HOLD      = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client and uart-side signals of the transmit arbiter.
// master: clients plus uart (environment); slave: the arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        grant;
    logic [IDX_W-1:0]          active_id;
    logic [BYTE_W-1:0]         din;
    logic                      wr_en;
    logic                      tx_busy;
    logic                      pkt_done;
    logic                      pkt_abort;

    modport master (
        output req, req_data, req_last, tx_busy,
        input  ack, grant, active_id, din, wr_en, pkt_done, pkt_abort
    );

    modport slave (
        input  req, req_data, req_last, tx_busy,
        output ack, grant, active_id, din, wr_en, pkt_done, pkt_abort
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               any
);

    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0] pos;
    logic           found;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        pos      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= N_L) begin
                pos = pos - N_L;
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                 = 1'b1;
                pick[pos[IDX_W-1:0]]  = 1'b1;
                pick_idx              = pos[IDX_W-1:0];
            end
        end
        any = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart transmitter
// between NUM_REQ byte-stream clients.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned HOLD_MAX = 255
) (
    input logic              clk_50m,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(HOLD_MAX);
    localparam logic [IDX_W-1:0]      LAST_ID  = IDX_W'(NUM_REQ - 1);

    arb_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [IDX_W-1:0]        active_id_q, active_id_d;
    logic [BYTE_W-1:0]       din_q, din_d;
    logic                    wr_en_q, wr_en_d;
    logic                    pkt_done_q, pkt_done_d;
    logic                    pkt_abort_q, pkt_abort_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                    last_q, last_d;

    logic [NUM_REQ-1:0]      pick;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;

    logic                    load_en;
    logic [IDX_W-1:0]        load_idx;
    logic [NUM_REQ-1:0]      load_grant;
    logic [IDX_W-1:0]        ptr_next;
    logic [HOLD_CNT_W-1:0]   hold_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (bus.req),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.active_id = active_id_q;
    assign bus.din       = din_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.pkt_abort = pkt_abort_q;

    // Next-state logic; byte loads from IDLE and HOLD share one load path.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ack_d       = '0;
        active_id_d = active_id_q;
        din_d       = din_q;
        wr_en_d     = 1'b0;
        pkt_done_d  = 1'b0;
        pkt_abort_d = 1'b0;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        last_d      = last_q;

        load_en    = 1'b0;
        load_idx   = active_id_q;
        load_grant = grant_q;
        ptr_next   = (active_id_q == LAST_ID) ? '0 : active_id_q + 1'b1;
        hold_inc   = hold_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                // Never start a byte while the uart may still be shifting.
                if (!bus.tx_busy && pick_any) begin
                    load_en    = 1'b1;
                    load_idx   = pick_idx;
                    load_grant = pick;
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        pkt_done_d = 1'b1;
                        grant_d    = '0;
                        ptr_d      = ptr_next;
                        hold_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.req[active_id_q]) begin
                    load_en = 1'b1;
                end else if (hold_inc == HOLD_LIM) begin
                    pkt_abort_d = 1'b1;
                    grant_d     = '0;
                    ptr_d       = ptr_next;
                    hold_cnt_d  = '0;
                    state_d     = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_en) begin
            grant_d     = load_grant;
            ack_d       = load_grant;
            active_id_d = load_idx;
            wr_en_d     = 1'b1;
            last_d      = bus.req_last[load_idx];
            hold_cnt_d  = '0;
            state_d     = ST_WAIT_BUSY;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (load_idx == IDX_W'(i)) begin
                    din_d = bus.req_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // State and registered outputs; synchronous reset.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ack_q       <= '0;
            active_id_q <= '0;
            din_q       <= '0;
            wr_en_q     <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_abort_q <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            active_id_q <= active_id_d;
            din_q       <= din_d;
            wr_en_q     <= wr_en_d;
            pkt_done_q  <= pkt_done_d;
            pkt_abort_q <= pkt_abort_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart loopback, per-client byte
// queues, and an expected-byte scoreboard filled as stimulus is issued.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned IDXW     = 2;
    localparam int unsigned HMAX     = 255;
    localparam int unsigned BUSY_CYC = 12;
    localparam int          LIMIT    = 3000;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ), .IDX_W(IDXW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ  (NREQ),
        .IDX_W    (IDXW),
        .HOLD_MAX (HMAX)
    ) dut (
        .clk_50m (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0]      cq [NREQ][$];
    logic [7:0]      sb [$];
    int unsigned     cyc = 0;
    int unsigned     busy_cnt = 0;
    int unsigned     fall_cyc = 0;
    int unsigned     abort_lat = 0;
    int unsigned     done_cnt = 0;
    int unsigned     abort_cnt = 0;
    int unsigned     ack_cnt [NREQ];
    logic [7:0]      shreg = '0;
    logic            prev_wr = 1'b0;
    logic [NREQ-1:0] prev_grant = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        logic [8:0] e;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (cq[i].size() != 0) begin
                e = cq[i][0];
                bus.req[i]             = 1'b1;
                bus.req_data[i*8 +: 8] = e[7:0];
                bus.req_last[i]        = e[8];
            end else begin
                bus.req[i] = 1'b0;
            end
        end
    endtask

    task automatic push(input int c, input logic [7:0] d, input logic last);
        cq[c].push_back({last, d});
        sb.push_back(d);
        drive_inputs();
    endtask

    function automatic bit clients_empty();
        for (int i = 0; i < int'(NREQ); i++) begin
            if (cq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: sample DUT at negedge, run uart model and clients, re-drive.
    task automatic tick();
        logic [NREQ-1:0] g;
        logic [7:0]      exp;
        @(negedge clk);
        cyc++;
        if (bus.grant != '0) begin
            g = '0;
            g[bus.active_id] = 1'b1;
            chk("grant_vs_active_id", 32'(bus.grant), 32'(g));
        end
        if (prev_grant != '0 && bus.grant != prev_grant) begin
            chk("grant_only_released", 32'(bus.grant), 32'(0));
        end
        prev_grant = bus.grant;

        if (bus.wr_en) begin
            chk("wr_en_while_busy", 32'(bus.tx_busy), 32'(0));
            chk("wr_en_single_pulse", 32'(prev_wr), 32'(0));
            shreg       = bus.din;
            busy_cnt    = BUSY_CYC;
            bus.tx_busy = 1'b1;
        end else if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                bus.tx_busy = 1'b0;
                fall_cyc    = cyc;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL rx_extra observed=0x%0h expected=none", shreg);
                end
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    chk("rx_byte", 32'(shreg), 32'(exp));
                end
            end
        end
        prev_wr = bus.wr_en;

        for (int i = 0; i < int'(NREQ); i++) begin
            if (bus.ack[i]) begin
                ack_cnt[i]++;
                chk("ack_owner", 32'(bus.grant[i]), 32'(1));
                checks++;
                assert (cq[i].size() != 0) else begin
                    errors++;
                    $error("FAIL ack_extra client=%0d observed=ack expected=no_ack", i);
                end
                if (cq[i].size() != 0) void'(cq[i].pop_front());
            end
        end

        if (bus.pkt_done) begin
            done_cnt++;
            chk("done_grant_clear", 32'(bus.grant), 32'(0));
        end
        if (bus.pkt_abort) begin
            abort_cnt++;
            abort_lat = cyc - fall_cyc;
            chk("abort_grant_clear", 32'(bus.grant), 32'(0));
        end
        drive_inputs();
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < LIMIT; n++) begin
            if (clients_empty() && sb.size() == 0 && busy_cnt == 0 && bus.grant == '0) break;
            tick();
        end
        checks++;
        assert (clients_empty() && sb.size() == 0 && busy_cnt == 0 && bus.grant == '0) else begin
            errors++;
            $error("FAIL %s_timeout observed=pending=%0d expected=0", tag, sb.size());
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_grant"},     32'(bus.grant),     32'(0));
        chk({tag, "_ack"},       32'(bus.ack),       32'(0));
        chk({tag, "_wr_en"},     32'(bus.wr_en),     32'(0));
        chk({tag, "_din"},       32'(bus.din),       32'(0));
        chk({tag, "_active_id"}, 32'(bus.active_id), 32'(0));
        chk({tag, "_pkt_done"},  32'(bus.pkt_done),  32'(0));
        chk({tag, "_pkt_abort"}, 32'(bus.pkt_abort), 32'(0));
    endtask

    initial begin
        int unsigned base_done, base_abort, base_ack;

        for (int i = 0; i < int'(NREQ); i++) ack_cnt[i] = 0;
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.tx_busy  = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Contention, two rounds, pointer starts at 0 both times.
        base_done = done_cnt;
        for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i), 1'b1);
        wait_idle("contention1");
        chk("contention1_done", done_cnt - base_done, 4);
        base_done = done_cnt;
        for (int i = 0; i < 4; i++) push(i, 8'hB0 + 8'(i), 1'b1);
        wait_idle("contention2");
        chk("contention2_done", done_cnt - base_done, 4);

        // Single client, two-byte packet; wr_en one cycle after req.
        base_done = done_cnt;
        base_ack  = ack_cnt[0];
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b1);
        tick();
        chk("latency_wr_en", 32'(bus.wr_en), 32'(1));
        chk("latency_grant", 32'(bus.grant), 32'h1);
        chk("latency_din",   32'(bus.din),   32'h41);
        wait_idle("single");
        chk("single_acks", ack_cnt[0] - base_ack, 2);
        chk("single_done", done_cnt - base_done, 1);

        // Packet lock: client 1 three bytes while client 2 waits.
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(2, 8'h20, 1'b1);
        wait_idle("packet_lock");

        // Wrap: pointer is now 3; clients 0 and 2 request, 0 goes first.
        push(0, 8'h30, 1'b1);
        push(2, 8'h32, 1'b1);
        wait_idle("wrap");

        // Hold timeout: client 0 stalls mid-packet, client 3 pending.
        base_done  = done_cnt;
        base_abort = abort_cnt;
        push(0, 8'h55, 1'b0);
        for (int n = 0; n < LIMIT && bus.grant != 4'b0001; n++) tick();
        chk("hold_grant0", 32'(bus.grant), 32'h1);
        push(3, 8'h63, 1'b1);
        for (int n = 0; n < LIMIT && abort_cnt == base_abort; n++) tick();
        chk("hold_abort_count", abort_cnt - base_abort, 1);
        chk("hold_abort_latency", abort_lat, HMAX + 1);
        for (int n = 0; n < LIMIT && bus.grant == '0; n++) tick();
        chk("hold_next_grant", 32'(bus.grant), 32'h8);
        wait_idle("hold");
        chk("hold_done", done_cnt - base_done, 1);
        chk("hold_abort_total", abort_cnt - base_abort, 1);

        // Reset while the uart is shifting a byte.
        push(1, 8'h77, 1'b1);
        for (int n = 0; n < LIMIT && !bus.tx_busy; n++) tick();
        chk("midbyte_busy", 32'(bus.tx_busy), 32'(1));
        push(2, 8'h88, 1'b1);
        rst = 1'b1;
        tick();
        check_outputs_zero("midbyte_reset");
        rst = 1'b0;
        wait_idle("midbyte");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
